// File: rtl/decode_buffer.sv
// decode_buffer: multi-lane MIPS-I decode stage feeding a circular queue of
// decoded instructions. Up to LANES entries are pushed and presented per cycle.
// Issue groups end at the first trapping entry (ri/syscall/break/eret).
module decode_buffer #(
  parameter int unsigned LANES = 2,
  parameter int unsigned DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [LANES-1:0]             in_valid,
  input  logic [32*LANES-1:0]          in_instr,
  input  logic [32*LANES-1:0]          in_pc,
  output logic                         in_ready,
  output logic [LANES-1:0]             out_valid,
  output logic [32*LANES-1:0]          out_instr,
  output logic [32*LANES-1:0]          out_pc,
  output logic [17*LANES-1:0]          out_ctrl,
  input  logic [$clog2(LANES+1)-1:0]   out_pop,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int unsigned PW     = $clog2(LANES + 1);
  localparam int unsigned PTRW   = $clog2(DEPTH);
  localparam int unsigned CW     = PTRW + 1;
  localparam int unsigned CTRL_W = 17;

  // Control word bit positions
  localparam int unsigned B_RI        = 16;
  localparam int unsigned B_SYSCALL   = 15;
  localparam int unsigned B_BREK      = 14;
  localparam int unsigned B_ERET      = 13;
  localparam int unsigned B_CP0_WEN   = 12;
  localparam int unsigned B_CP0TOREG  = 11;
  localparam int unsigned B_HILO_WEN  = 10;
  localparam int unsigned B_HILOTOREG = 9;
  localparam int unsigned B_PCTOREG   = 8;
  localparam int unsigned B_MEMREAD   = 7;
  localparam int unsigned B_REGWRITE  = 6;
  localparam int unsigned B_REGDST    = 5;
  localparam int unsigned B_ALUSRC    = 4;
  localparam int unsigned B_BRANCH    = 3;
  localparam int unsigned B_MEMWRITE  = 2;
  localparam int unsigned B_MEMTOREG  = 1;
  localparam int unsigned B_JUMP      = 0;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

  // Queue storage (not reset: contents are only observed through count)
  logic [31:0]       instr_q [DEPTH];
  logic [31:0]       pc_q    [DEPTH];
  logic [CTRL_W-1:0] ctrl_q  [DEPTH];

  logic [PTRW-1:0] head_q, head_d;
  logic [PTRW-1:0] tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;

  logic [PW-1:0]     lead_ones;
  logic              run;
  logic [PW-1:0]     push_n;
  logic [LANES-1:0]  wr_en;
  logic [CTRL_W-1:0] dec_ctrl [LANES];
  logic [PW-1:0]     nvalid;
  logic [PW-1:0]     pop_n;
  logic              trap_seen;
  logic [PTRW-1:0]   rd_idx;

  // Single-instruction MIPS-I decoder producing the 17-bit control word
  function automatic logic [CTRL_W-1:0] decode_instr(input logic [31:0] instr);
    logic [CTRL_W-1:0] c;
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    c     = '0;
    op    = instr[31:26];
    rs    = instr[25:21];
    rt    = instr[20:16];
    funct = instr[5:0];
    case (op)
      6'h00: begin
        case (funct)
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: begin
            c[B_REGWRITE] = 1'b1;
            c[B_REGDST]   = 1'b1;
          end
          6'h08: c = '0;
          6'h09: begin
            c[B_REGWRITE] = 1'b1;
            c[B_REGDST]   = 1'b1;
            c[B_PCTOREG]  = 1'b1;
          end
          6'h0C: c[B_SYSCALL] = 1'b1;
          6'h0D: c[B_BREK]    = 1'b1;
          6'h10, 6'h12: begin
            c[B_REGWRITE]  = 1'b1;
            c[B_REGDST]    = 1'b1;
            c[B_HILOTOREG] = 1'b1;
          end
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c[B_HILO_WEN] = 1'b1;
          default: c[B_RI] = 1'b1;
        endcase
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: c[B_BRANCH] = 1'b1;
          5'h10, 5'h11: begin
            c[B_REGWRITE] = 1'b1;
            c[B_REGDST]   = 1'b1;
            c[B_BRANCH]   = 1'b1;
            c[B_PCTOREG]  = 1'b1;
          end
          default: c[B_RI] = 1'b1;
        endcase
      end
      6'h02: c[B_JUMP] = 1'b1;
      6'h03: begin
        c[B_REGWRITE] = 1'b1;
        c[B_REGDST]   = 1'b1;
        c[B_JUMP]     = 1'b1;
        c[B_PCTOREG]  = 1'b1;
      end
      6'h04, 6'h05, 6'h06, 6'h07: c[B_BRANCH] = 1'b1;
      6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
        c[B_REGWRITE] = 1'b1;
        c[B_ALUSRC]   = 1'b1;
      end
      6'h10: begin
        if (instr == ERET_WORD) begin
          c[B_ERET] = 1'b1;
        end else if (rs == 5'h00) begin
          c[B_REGWRITE]  = 1'b1;
          c[B_CP0TOREG]  = 1'b1;
        end else if (rs == 5'h04) begin
          c[B_CP0_WEN] = 1'b1;
        end else begin
          c[B_RI] = 1'b1;
        end
      end
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
        c[B_REGWRITE] = 1'b1;
        c[B_ALUSRC]   = 1'b1;
        c[B_MEMTOREG] = 1'b1;
        c[B_MEMREAD]  = 1'b1;
      end
      6'h28, 6'h29, 6'h2A, 6'h2B, 6'h2E: begin
        c[B_ALUSRC]   = 1'b1;
        c[B_MEMWRITE] = 1'b1;
      end
      default: c[B_RI] = 1'b1;
    endcase
    return c;
  endfunction

  // Room for a full LANES-wide push, judged on occupancy before any pop
  assign in_ready = (count_q <= CW'(DEPTH - LANES));
  assign count    = count_q;

  // Push count: leading contiguous valid lanes, zero when not ready or flushing
  always_comb begin
    lead_ones = '0;
    run       = 1'b1;
    for (int unsigned i = 0; i < LANES; i++) begin
      run = run & in_valid[i];
      if (run) lead_ones = lead_ones + PW'(1);
    end
    push_n = (in_ready && !flush && !rst) ? lead_ones : '0;
    wr_en  = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_en[i] = (PW'(i) < push_n);
    end
  end

  // Per-lane decode of the incoming instruction words
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      dec_ctrl[i] = decode_instr(in_instr[32*i +: 32]);
    end
  end

  // Write accepted lanes into consecutive slots starting at tail
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_en[i]) begin
        instr_q[tail_q + PTRW'(i)] <= in_instr[32*i +: 32];
        pc_q[tail_q + PTRW'(i)]    <= in_pc[32*i +: 32];
        ctrl_q[tail_q + PTRW'(i)]  <= dec_ctrl[i];
      end
    end
  end

  // Present in-order entries from head, ending the group after a trap entry
  always_comb begin
    out_valid = '0;
    out_instr = '0;
    out_pc    = '0;
    out_ctrl  = '0;
    trap_seen = 1'b0;
    nvalid    = '0;
    rd_idx    = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      rd_idx = head_q + PTRW'(k);
      if ((count_q > CW'(k)) && !trap_seen) begin
        out_valid[k]           = 1'b1;
        out_instr[32*k +: 32]  = instr_q[rd_idx];
        out_pc[32*k +: 32]     = pc_q[rd_idx];
        out_ctrl[17*k +: 17]   = ctrl_q[rd_idx];
        trap_seen              = |ctrl_q[rd_idx][B_RI:B_ERET];
        nvalid                 = nvalid + PW'(1);
      end
    end
  end

  // Effective pop saturates at the presented entry count; pointer/count next-state
  always_comb begin
    pop_n   = (out_pop > nvalid) ? nvalid : out_pop;
    head_d  = head_q + PTRW'(pop_n);
    tail_d  = tail_q + PTRW'(push_n);
    count_d = count_q + CW'(push_n) - CW'(pop_n);
  end

  // Queue pointers and occupancy; reset and flush empty the queue
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_decode_buffer.sv
// Directed bench for decode_buffer (LANES=2, DEPTH=8).
module tb_decode_buffer;

  localparam logic [31:0] ADDU    = 32'h0085_1021;
  localparam logic [31:0] LW      = 32'h8C82_0004;
  localparam logic [31:0] SYSCALL = 32'h0000_000C;
  localparam logic [31:0] BRK     = 32'h0000_000D;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [1:0]  in_valid;
  logic [63:0] in_instr;
  logic [63:0] in_pc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_instr;
  logic [63:0] out_pc;
  logic [33:0] out_ctrl;
  logic [1:0]  out_pop;
  logic [3:0]  count;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [16:0] ctrl;
  } vec_t;

  vec_t vecs [0:22];

  decode_buffer #(.LANES(2), .DEPTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ctrl  (out_ctrl),
    .out_pop   (out_pop),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  logic [31:0] exp_pc;
  logic [31:0] push_pc;

  initial begin
    // Decode table: instruction word and its expected control word
    vecs[0]  = '{32'h0085_1021, 17'h00060};  // addu
    vecs[1]  = '{32'h8C82_0004, 17'h000D2};  // lw
    vecs[2]  = '{32'hAC82_0004, 17'h00014};  // sw
    vecs[3]  = '{32'h1085_0003, 17'h00008};  // beq
    vecs[4]  = '{32'h0411_0004, 17'h00168};  // bgezal
    vecs[5]  = '{32'h0405_0004, 17'h10000};  // regimm rt=5 undefined
    vecs[6]  = '{32'h2442_0001, 17'h00050};  // addiu
    vecs[7]  = '{32'h3C01_1234, 17'h00050};  // lui
    vecs[8]  = '{32'h0800_0040, 17'h00001};  // j
    vecs[9]  = '{32'h0C00_0040, 17'h00161};  // jal
    vecs[10] = '{32'h03E0_0008, 17'h00000};  // jr
    vecs[11] = '{32'h0040_F809, 17'h00160};  // jalr
    vecs[12] = '{32'h0085_0018, 17'h00400};  // mult
    vecs[13] = '{32'h0000_1010, 17'h00260};  // mfhi
    vecs[14] = '{32'h0080_0013, 17'h00400};  // mtlo
    vecs[15] = '{32'h4002_6000, 17'h00840};  // mfc0
    vecs[16] = '{32'h4082_6000, 17'h01000};  // mtc0
    vecs[17] = '{32'h4200_0018, 17'h02000};  // eret
    vecs[18] = '{32'h0000_000C, 17'h08000};  // syscall
    vecs[19] = '{32'h0000_000D, 17'h04000};  // break
    vecs[20] = '{32'hFC00_0000, 17'h10000};  // illegal opcode
    vecs[21] = '{32'h0000_0001, 17'h10000};  // undefined funct
    vecs[22] = '{32'h0002_1080, 17'h00060};  // sll

    rst = 1'b1; flush = 1'b0; in_valid = '0; in_instr = '0; in_pc = '0; out_pop = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("rst_count", 64'(count), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_ctrl", 64'(out_ctrl), 64'd0);

    // First push: ADDU + LW
    in_instr = {LW, ADDU}; in_pc = {32'h104, 32'h100}; in_valid = 2'b11;
    tick();
    in_valid = '0;
    check("p1_valid", 64'(out_valid), 64'd3);
    check("p1_count", 64'(count), 64'd2);
    check("p1_ctrl0", 64'(out_ctrl[16:0]), 64'h060);
    check("p1_ctrl1", 64'(out_ctrl[33:17]), 64'h0D2);
    check("p1_pc", out_pc, {32'h104, 32'h100});
    out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("p1_drain", 64'(count), 64'd0);

    // Table-driven decode checks, one entry at a time
    for (int i = 0; i < 23; i++) begin
      in_instr = {32'h0, vecs[i].instr};
      in_pc    = {32'h0, 32'h1000 + 32'(4 * i)};
      in_valid = 2'b01;
      tick();
      in_valid = '0;
      check($sformatf("dec%0d_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("dec%0d_ctrl", i), 64'(out_ctrl[16:0]), 64'(vecs[i].ctrl));
      check($sformatf("dec%0d_instr", i), 64'(out_instr[31:0]), 64'(vecs[i].instr));
      out_pop = 2'd1;
      tick();
      out_pop = '0;
    end
    check("dec_drain", 64'(count), 64'd0);

    // Non-leading valid lane is ignored
    in_instr = {ADDU, ADDU}; in_pc = {32'h304, 32'h300}; in_valid = 2'b10;
    tick();
    in_valid = '0;
    check("gap_count", 64'(count), 64'd0);

    // Pop saturation: one entry, pop 3; then pop on empty
    in_valid = 2'b01;
    tick();
    in_valid = '0;
    out_pop = 2'd3;
    tick();
    check("sat_count", 64'(count), 64'd0);
    out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("empty_pop_count", 64'(count), 64'd0);
    check("empty_pop_valid", 64'(out_valid), 64'd0);

    // Fill to full, then one dropped push, then pop
    in_instr = {ADDU, ADDU};
    for (int c = 0; c < 4; c++) begin
      in_pc = {32'h204 + 32'(8 * c), 32'h200 + 32'(8 * c)};
      in_valid = 2'b11;
      tick();
    end
    check("full_count", 64'(count), 64'd8);
    check("full_ready", 64'(in_ready), 64'd0);
    in_pc = {32'h224, 32'h220};
    tick();
    in_valid = '0;
    check("full_drop_count", 64'(count), 64'd8);
    check("full_head_pc", out_pc, {32'h204, 32'h200});
    out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("after_pop_count", 64'(count), 64'd6);
    check("after_pop_ready", 64'(in_ready), 64'd1);
    check("after_pop_pc", out_pc, {32'h20C, 32'h208});
    out_pop = 2'd2;
    tick(); tick();
    out_pop = '0;
    check("fill_last_pc", out_pc, {32'h21C, 32'h218});
    out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("fill_drain", 64'(count), 64'd0);

    // Sustained push 2 / pop 2 across pointer wrap
    in_pc = {32'h404, 32'h400}; in_valid = 2'b11;
    tick();
    exp_pc  = 32'h400;
    push_pc = 32'h408;
    for (int c = 0; c < 20; c++) begin
      check($sformatf("wrap%0d_pc", c), out_pc, {exp_pc + 32'd4, exp_pc});
      in_pc = {push_pc + 32'd4, push_pc}; in_valid = 2'b11; out_pop = 2'd2;
      tick();
      check($sformatf("wrap%0d_count", c), 64'(count), 64'd2);
      exp_pc  = exp_pc + 32'd8;
      push_pc = push_pc + 32'd8;
    end
    in_valid = '0; out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("wrap_drain", 64'(count), 64'd0);

    // Trap fence: SYSCALL at head closes the group
    in_instr = {ADDU, SYSCALL}; in_pc = {32'h504, 32'h500}; in_valid = 2'b11;
    tick();
    in_valid = '0;
    check("fence_valid", 64'(out_valid), 64'd1);
    check("fence_ctrl0", 64'(out_ctrl[16:0]), 64'h08000);
    check("fence_ctrl1", 64'(out_ctrl[33:17]), 64'd0);
    check("fence_instr1", 64'(out_instr[63:32]), 64'd0);
    out_pop = 2'd2;
    tick();
    out_pop = '0;
    check("fence_pop_count", 64'(count), 64'd1);
    check("fence_next_valid", 64'(out_valid), 64'd1);
    check("fence_next_instr", 64'(out_instr[31:0]), 64'(ADDU));
    check("fence_next_ctrl", 64'(out_ctrl[16:0]), 64'h060);
    out_pop = 2'd1;
    tick();
    out_pop = '0;

    // Trap in the last lane does not shorten the group
    in_instr = {BRK, ADDU}; in_pc = {32'h604, 32'h600}; in_valid = 2'b11;
    tick();
    in_valid = '0;
    check("tail_trap_valid", 64'(out_valid), 64'd3);
    check("tail_trap_ctrl1", 64'(out_ctrl[33:17]), 64'h04000);
    out_pop = 2'd2;
    tick();
    out_pop = '0;

    // Flush with same-cycle push and pop
    in_instr = {ADDU, ADDU};
    in_valid = 2'b11; tick(); tick();
    in_valid = 2'b01; tick();
    in_valid = '0;
    check("pre_flush_count", 64'(count), 64'd5);
    flush = 1'b1; in_valid = 2'b11; out_pop = 2'd2;
    tick();
    flush = 1'b0; in_valid = '0; out_pop = '0;
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(out_valid), 64'd0);
    check("flush_ready", 64'(in_ready), 64'd1);
    check("flush_pc", out_pc, 64'd0);
    in_pc = {32'h0, 32'h700}; in_valid = 2'b01;
    tick();
    in_valid = '0;
    check("post_flush_pc", out_pc, {32'h0, 32'h700});
    check("post_flush_count", 64'(count), 64'd1);
    out_pop = 2'd1; tick(); out_pop = '0;

    // Same with reset
    in_valid = 2'b11; tick(); tick();
    in_valid = 2'b01; tick();
    in_valid = '0;
    check("pre_rst_count", 64'(count), 64'd5);
    rst = 1'b1; in_valid = 2'b11; out_pop = 2'd2;
    tick();
    rst = 1'b0; in_valid = '0; out_pop = '0;
    check("rst2_count", 64'(count), 64'd0);
    check("rst2_valid", 64'(out_valid), 64'd0);
    check("rst2_ready", 64'(in_ready), 64'd1);
    check("rst2_ctrl", 64'(out_ctrl), 64'd0);
    in_pc = {32'h0, 32'h800}; in_valid = 2'b01;
    tick();
    in_valid = '0;
    check("post_rst_pc", out_pc, {32'h0, 32'h800});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_buffer.md
Name: decode_buffer

Overview:
- Multi-lane decode stage plus a decoded-instruction queue for the superscalar MIPS-I core.
- Each cycle it accepts up to LANES fetched instructions, decodes each one into a registered control word, and buffers them in a circular queue of DEPTH entries.
- It presents up to LANES in-order entries to issue, and issue retires a variable count per cycle.
- It adds two behaviours the single-lane combinational decoder lacks: buffering with backpressure, and trap-fenced issue groups.

Parameters:
- LANES, 2, instructions accepted and presented per cycle (1..4).
- DEPTH, 8, queue entries; must be a power of two and at least 2*LANES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard every queued entry (exception or branch redirect).
- in_valid  in  LANES  per-lane fetch valid; lane 0 is oldest.
- in_instr  in  32*LANES  instruction words; lane i is at [32i+31:32i].
- in_pc  in  32*LANES  PC per lane.
- in_ready  out  1  queue can take LANES entries this cycle.
- out_valid  out  LANES  entry head+k is presentable.
- out_instr  out  32*LANES  instruction at head+k.
- out_pc  out  32*LANES  PC at head+k.
- out_ctrl  out  17*LANES  decoded control word at head+k.
- out_pop  in  clog2(LANES+1)  number of entries issue consumes this cycle.
- count  out  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Control word layout, MSB to LSB: {ri, syscall, brek, eret, cp0_wen, cp0toreg, hilo_wen, hilotoreg, pctoreg, memread, regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump}.
- Decode uses the team opcode defines:
  - R-type ALU, shift, MFHI, MFLO, JALR: regwrite, regdst. JALR also sets pctoreg.
  - MULT, MULTU, DIV, DIVU, MTHI, MTLO: hilo_wen only. MFHI and MFLO also set hilotoreg.
  - JR: all zero. SYSCALL: syscall. BREAK: brek.
  - Loads: regwrite, alusrc, memtoreg, memread. Stores: alusrc, memwrite.
  - BEQ, BNE, BGTZ, BLEZ, BGEZ, BLTZ: branch.
  - BGEZAL, BLTZAL: regwrite, regdst, branch, pctoreg.
  - Immediate ALU ops and LUI: regwrite, alusrc.
  - J: jump. JAL: regwrite, regdst, jump, pctoreg.
  - MFC0: regwrite, cp0toreg. MTC0: cp0_wen.
  - ERET (exact word 0x42000018): eret.
  - Any other encoding, including unlisted REGIMM rt values: ri=1, all other bits 0.
- Decode is registered on push. An entry pushed in cycle N is visible on the outputs in cycle N+1 at the earliest.
- Push:
  - Occurs only when in_ready=1.
  - Push count = number of leading contiguous set bits of in_valid. Lanes after the first 0 are ignored.
  - Lane i is written to tail+i.
- in_ready = (DEPTH - count) >= LANES, computed from count before any same-cycle pop.
- Pop:
  - Effective pop = min(out_pop, number of set out_valid bits). Excess is silently saturated.
  - head advances by the effective pop.
- Simultaneous push and pop in one cycle is legal: count_next = count + push - pop.
- Pointers wrap modulo DEPTH.
- Presentation:
  - Base rule: out_valid[k] = (count > k).
  - Trap fence: if an entry at head+j has any of ri, syscall, brek, eret set, then out_valid[k] is forced to 0 for all k > j. The trap entry is therefore the last in its issue group.
- Lanes with out_valid[k]=0 drive 0 on out_instr, out_pc and out_ctrl.
- Flush takes priority over push and pop in the same cycle: head, tail and count go to 0, and any same-cycle push is dropped.
- Reset (synchronous): same effect as flush. All outputs are 0 in the cycle after rst. in_ready=1 once count=0.
- Reset or flush mid-operation discards partially issued groups with no residue.
- Full: count=DEPTH gives in_ready=0. count > DEPTH-LANES also gives in_ready=0.
- Empty: out_valid is all 0, and out_pop is ignored.

Test Plan:
- Post-reset push of ADDU (0x00851021 @0x100) and LW (0x8C820004 @0x104):
  - Next cycle: out_valid=2'b11, count=2.
  - out_ctrl lane0 has regwrite and regdst only.
  - out_ctrl lane1 has regwrite, alusrc, memtoreg and memread.
- Fill:
  - Push 2 per cycle with out_pop=0 for 4 cycles: count=8, in_ready=0.
  - A fifth push attempt is dropped, count stays 8.
  - Then out_pop=2: count=6 and in_ready=1 the following cycle.
- Wrap and concurrency:
  - Sustain push 2 / pop 2 for 20 cycles: count constant.
  - out_pc sequence strictly increments by 4 across the pointer wrap.
- Trap fence:
  - Queue SYSCALL (0x0000000C) at head and ADDU at head+1.
  - Expect out_valid=2'b01 with lane0 syscall=1. After pop 1, ADDU is presented at lane0.
- Illegal op: instruction 0xFC000000 gives ri=1 and all other control bits 0. ERET 0x42000018 gives eret=1 and ri=0.
- Flush:
  - With count=5, assert flush together with a 2-lane push and out_pop=2.
  - Next cycle: count=0, out_valid=0, in_ready=1.
  - Same check with rst in place of flush.
